// File: rtl/rbank_arb.sv
// Round-robin arbiter that shares a single-port register bank between NREQ requesters.
// Sequences write (WR) and two-cycle read (RDA/RDB) timing and returns read data to the winner.
module rbank_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int SW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arb_hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*SW-1:0]   req_sel,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 bank_we,
    output logic [SW-1:0]        bank_sel,
    output logic [DW-1:0]        bank_in,
    input  logic [DW-1:0]        bank_out
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RDA,
        RDB
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LW-1:0]     r_last;
    logic [LW-1:0]     r_owner;
    logic [SW-1:0]     r_bank_sel;
    logic [DW-1:0]     r_bank_in;

    logic [LW-1:0]     w_cand;
    logic [LW-1:0]     w_gidx;
    logic              w_found;
    logic              w_window;
    logic              w_accept;
    logic              w_acc_we;
    logic [SW-1:0]     w_sel;
    logic [DW-1:0]     w_wdata;

    // Search starts one past the last winner so the previous owner has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = LW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    // Reset gates ready combinationally so nothing is granted while it is held low.
    assign w_window  = reset && (r_state != RDA) && !arb_hold;
    assign w_accept  = w_found && w_window;
    assign w_acc_we  = req_we[w_gidx];
    assign w_sel     = req_sel[int'(w_gidx)*SW +: SW];
    assign w_wdata   = req_wdata[int'(w_gidx)*DW +: DW];
    assign req_ready = w_accept ? (NREQ'(1) << w_gidx) : '0;

    always_comb begin
        w_state_nxt = IDLE;
        if (w_accept) begin
            w_state_nxt = w_acc_we ? WR : RDA;
        end else if (r_state == RDA) begin
            w_state_nxt = RDB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last     <= LW'(NREQ - 1);
            r_owner    <= '0;
            r_bank_sel <= '0;
            r_bank_in  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last     <= w_gidx;
                r_owner    <= w_gidx;
                r_bank_sel <= w_sel;
                if (w_acc_we) begin
                    r_bank_in <= w_wdata;
                end
            end
        end
    end

    // bank_sel stays put through RDB and idle cycles; read data is passed straight through in RDB.
    assign bank_we   = (r_state == WR);
    assign bank_sel  = r_bank_sel;
    assign bank_in   = r_bank_in;
    assign rsp_valid = (r_state == RDB) ? (NREQ'(1) << r_owner) : '0;
    assign rsp_data  = (r_state == RDB) ? bank_out : '0;

endmodule

// File: tb/tb_rbank_arb.sv
// Scoreboard bench for rbank_arb: a behavioural register bank plus a grant/timing model
// push expected bank and response activity, which is popped and compared cycle by cycle.
module tb_rbank_arb;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int SW   = 5;

    typedef enum int {K_WR, K_RDA, K_RDB} kind_e;

    typedef struct {
        int            due;
        kind_e         kind;
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
        int            req;
    } item_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               arb_hold = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ*SW-1:0] req_sel = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               bank_we;
    logic [SW-1:0]      bank_sel;
    logic [DW-1:0]      bank_in;
    logic [DW-1:0]      bank_out;

    logic               load_en = 1'b0;
    logic [SW-1:0]      load_sel = '0;
    logic [DW-1:0]      load_data = '0;
    logic [DW-1:0]      mem [32];
    logic [DW-1:0]      shadow [32];

    item_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    m_last = NREQ - 1;
    bit    m_rda = 1'b0;

    rbank_arb #(.NREQ(NREQ), .DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .arb_hold  (arb_hold),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_sel   (req_sel),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .bank_we   (bank_we),
        .bank_sel  (bank_sel),
        .bank_in   (bank_in),
        .bank_out  (bank_out)
    );

    always #5 clk = ~clk;

    // Single-port bank: write on the edge, registered read of the currently selected entry.
    always @(posedge clk) begin
        if (load_en) mem[load_sel] <= load_data;
        else if (bank_we) mem[bank_sel] <= bank_in;
        bank_out <= mem[bank_sel];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [SW-1:0] sel,
                           input logic [DW-1:0] wd);
        req_we[i]              = we;
        req_sel[i*SW +: SW]    = sel;
        req_wdata[i*DW +: DW]  = wd;
    endtask

    task automatic verify();
        item_t           it;
        bit              wr_seen = 1'b0;
        bit              rsp_seen = 1'b0;
        logic [NREQ-1:0] oh;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            it = sb.pop_front();
            case (it.kind)
                K_WR: begin
                    wr_seen = 1'b1;
                    check("wr_we", 64'(bank_we), 64'd1);
                    check("wr_sel", 64'(bank_sel), 64'(it.sel));
                    check("wr_in", bank_in, it.data);
                end
                K_RDA: begin
                    check("rda_we", 64'(bank_we), 64'd0);
                    check("rda_sel", 64'(bank_sel), 64'(it.sel));
                end
                default: begin
                    rsp_seen = 1'b1;
                    oh = '0;
                    oh[it.req] = 1'b1;
                    check("rdb_valid", 64'(rsp_valid), 64'(oh));
                    check("rdb_data", rsp_data, it.data);
                    check("rdb_sel", 64'(bank_sel), 64'(it.sel));
                end
            endcase
        end
        if (!wr_seen) check("we_idle", 64'(bank_we), 64'd0);
        if (!rsp_seen) check("rsp_idle", 64'(rsp_valid), 64'd0);
    endtask

    // One clock: drive requests, check the expected grant, record what the DUT owes, advance.
    task automatic cycle(input logic [NREQ-1:0] v, input logic hold);
        int              g = -1;
        logic [NREQ-1:0] exp_rdy = '0;
        logic [SW-1:0]   sel;
        bit              next_rda = 1'b0;
        req_valid = v;
        arb_hold  = hold;
        #1;
        for (int k = 1; k <= NREQ; k++) begin
            if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
        end
        if (!m_rda && !hold && g >= 0) exp_rdy[g] = 1'b1;
        check("ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy != '0) begin
            m_last = g;
            sel = req_sel[g*SW +: SW];
            if (req_we[g]) begin
                sb.push_back('{cyc + 1, K_WR, sel, req_wdata[g*DW +: DW], g});
                shadow[sel] = req_wdata[g*DW +: DW];
            end else begin
                sb.push_back('{cyc + 1, K_RDA, sel, '0, g});
                sb.push_back('{cyc + 2, K_RDB, sel, shadow[sel], g});
                next_rda = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        m_rda = next_rda;
        #1;
        verify();
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        arb_hold  = 1'b0;
        req_valid = '1;
        sb.delete();
        m_last = NREQ - 1;
        m_rda  = 1'b0;
        #1;
        check("rst_we", 64'(bank_we), 64'd0);
        check("rst_rsp", 64'(rsp_valid), 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_sel", 64'(bank_sel), 64'd0);
        check("rst_in", bank_in, 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        // Preload the bank while reset is held so every register has a known value.
        for (int i = 0; i < 32; i++) begin
            load_en   = 1'b1;
            load_sel  = SW'(i);
            load_data = (i == 7) ? 64'h1234 : 64'hC0DE_0000 + 64'(i);
            shadow[i] = load_data;
            @(posedge clk);
            #1;
        end
        load_en = 1'b0;
        apply_reset();

        // Single write, then an idle cycle with bank_we low.
        set_req(0, 1'b1, 5'd3, 64'hDEAD_BEEF);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);

        // Reset in the middle of a read, then all four request after release.
        set_req(2, 1'b0, 5'd7, '0);
        cycle(4'b0100, 1'b0);
        #2;
        apply_reset();

        // Four writers held for eight cycles: rotating grants, one write per cycle.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, SW'(10 + i), 64'h1000 + 64'(i));
        for (int n = 0; n < 8; n++) cycle(4'b1111, 1'b0);
        cycle(4'b0000, 1'b0);

        // Read of a preloaded register; request stays up during RDA and must not be granted.
        set_req(2, 1'b0, 5'd7, '0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);

        // Write then read of the same register back-to-back.
        set_req(1, 1'b1, 5'd9, 64'd5);
        cycle(4'b0010, 1'b0);
        set_req(1, 1'b0, 5'd9, '0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // Hold through a read; req3 is granted as soon as hold drops.
        set_req(2, 1'b0, 5'd7, '0);
        set_req(3, 1'b1, 5'd20, 64'hABCD);
        cycle(4'b0100, 1'b0);
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b1000, 1'b0);
        cycle(4'b0000, 1'b0);

        // Random mix of requests, directions, registers and hold.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 31)),
                        {$urandom, $urandom});
            end
            cycle(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end
        for (int n = 0; n < 3; n++) cycle(4'b0000, 1'b0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
